// File: rtl/imem_loader.sv
// Streams a program into instruction memory and holds the CPU in reset until the load completes.
// Optional running checksum of written words is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 10,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic [ADDR_W:0]   word_count,
   output logic              err_overflow,
   output logic [31:0]       checksum
);

   localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] WC_ONE    = (ADDR_W+1)'(1);
   localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
   localparam logic [HCW-1:0]  HOLD_ONE  = HCW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      HOLD  = 3'd2,
      RUN   = 3'd3,
      ERROR = 3'd4
   } state_t;

   state_t            state_r;
   logic [1:0]        sync_r;
   logic              run_ok_s;
   logic              accept_s;
   logic              full_s;
   logic              start_load_s;
   logic              in_ready_r;
   logic              im_we_r;
   logic [ADDR_W-1:0] im_addr_r;
   logic [31:0]       im_wdata_r;
   logic              cpu_rst_r;
   logic              load_done_r;
   logic [ADDR_W:0]   word_count_r;
   logic              err_r;
   logic [HCW-1:0]    hold_cnt_r;

   // Reset release synchroniser: assertion stays asynchronous, release takes two edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], 1'b1};
      end
   end

   assign run_ok_s     = sync_r[1];
   assign accept_s     = (state_r == LOAD) && in_valid && in_ready_r;
   assign full_s       = (word_count_r == DEPTH_C);
   assign start_load_s = run_ok_s && start &&
                         ((state_r == IDLE) || (state_r == RUN) || (state_r == ERROR));

   // Loader FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         in_ready_r   <= 1'b0;
         im_we_r      <= 1'b0;
         im_addr_r    <= {ADDR_W{1'b0}};
         im_wdata_r   <= 32'd0;
         cpu_rst_r    <= 1'b1;
         load_done_r  <= 1'b0;
         word_count_r <= {(ADDR_W+1){1'b0}};
         err_r        <= 1'b0;
         hold_cnt_r   <= {HCW{1'b0}};
      end else begin
         im_we_r <= 1'b0;
         if (start_load_s) begin
            state_r      <= LOAD;
            in_ready_r   <= 1'b1;
            cpu_rst_r    <= 1'b1;
            load_done_r  <= 1'b0;
            word_count_r <= {(ADDR_W+1){1'b0}};
            err_r        <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r <= IDLE;
               end
               LOAD: begin
                  if (accept_s && full_s) begin
                     state_r    <= ERROR;
                     err_r      <= 1'b1;
                     in_ready_r <= 1'b0;
                  end else if (accept_s) begin
                     im_we_r      <= 1'b1;
                     im_addr_r    <= word_count_r[ADDR_W-1:0];
                     im_wdata_r   <= in_data;
                     word_count_r <= word_count_r + WC_ONE;
                     if (in_last) begin
                        state_r    <= HOLD;
                        in_ready_r <= 1'b0;
                        hold_cnt_r <= {HCW{1'b0}};
                     end else begin
                        state_r <= LOAD;
                     end
                  end else begin
                     state_r <= LOAD;
                  end
               end
               HOLD: begin
                  if (hold_cnt_r == HOLD_LAST) begin
                     state_r     <= RUN;
                     cpu_rst_r   <= 1'b0;
                     load_done_r <= 1'b1;
                  end else begin
                     hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                  end
               end
               RUN: begin
                  state_r <= RUN;
               end
               ERROR: begin
                  state_r <= ERROR;
               end
               default: begin
                  state_r     <= IDLE;
                  in_ready_r  <= 1'b0;
                  cpu_rst_r   <= 1'b1;
                  load_done_r <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum_r;

   // Running mod-2^32 sum, updated on the same edge that issues the write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_r <= 32'd0;
      end else if (start_load_s) begin
         checksum_r <= 32'd0;
      end else if (accept_s && !full_s) begin
         checksum_r <= checksum_r + in_data;
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign checksum = checksum_r;
`else
   assign checksum = 32'd0;
`endif

   assign in_ready     = in_ready_r;
   assign im_we        = im_we_r;
   assign im_addr      = im_addr_r;
   assign im_wdata     = im_wdata_r;
   assign cpu_rst      = cpu_rst_r;
   assign load_done    = load_done_r;
   assign word_count   = word_count_r;
   assign err_overflow = err_r;

endmodule
